// File: rtl/game2048_pkg.sv
// Shared types, constants and helpers for the 2048 move sequencer.
// Cell k of a board sits at bits [63-4k -: 4]; k = 4*row + col.
package game2048_pkg;

  typedef logic [3:0]  cell_t;
  typedef logic [63:0] board_t;
  typedef logic [3:0]  dir_t;

  localparam dir_t DIR_UP    = 4'b1000;
  localparam dir_t DIR_DOWN  = 4'b0100;
  localparam dir_t DIR_LEFT  = 4'b0010;
  localparam dir_t DIR_RIGHT = 4'b0001;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_WON  = 2'b01;
  localparam logic [1:0] ST_LOST = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MERGE    = 3'd2,
    SPAWN    = 3'd3,
    CHECK    = 3'd4,
    WRITE    = 3'd5,
    WAIT_REL = 3'd6
  } state_t;

  // Board cell for position j of line i, with j = 0 at the move edge.
  function automatic logic [3:0] cell_idx(
    input dir_t       d,
    input logic [1:0] i,
    input logic [1:0] j
  );
    logic [3:0] k;
    unique case (1'b1)
      d[3]:    k = {j, i};
      d[2]:    k = {~j, i};
      d[1]:    k = {i, j};
      d[0]:    k = {i, ~j};
      default: k = {i, j};
    endcase
    return k;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Slides one 4-cell line toward index 0 and merges equal neighbours once.
// Purely combinational; shared by all four move directions.
module line_merge
  import game2048_pkg::*;
(
  input  cell_t [3:0] line_in,
  output cell_t [3:0] line_out
);

  cell_t      c [5];
  logic [1:0] n;
  logic [1:0] m;
  logic       skip;

  always_comb begin
    for (int j = 0; j < 5; j++) c[j] = '0;
    n = '0;
    for (int j = 0; j < 4; j++) begin
      if (line_in[j] != '0) begin
        c[{1'b0, n}] = line_in[j];
        n = n + 2'd1;
      end
    end
    line_out = '0;
    m        = '0;
    skip     = 1'b0;
    // c[4] stays empty so the last compacted cell never pairs
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[j] != '0) begin
        if (c[j] == c[j+1]) begin
          line_out[m] = (c[j] == 4'hF) ? 4'hF : c[j] + 4'd1;
          skip = 1'b1;
        end else begin
          line_out[m] = c[j];
        end
        m = m + 2'd1;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// One 2048 move per key press: load, merge 4 lines, spawn, check, write.
// Define MOVE_COUNT_EN to add the saturating move_count output.
module move_sequencer
  import game2048_pkg::*;
#(
  parameter int          WIN_VALUE = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  direction,
  input  logic [63:0] board_in,
  output logic [63:0] board_out,
  output logic        board_we,
  output logic        busy,
  output logic [1:0]  end_status,
  output logic [2:0]  state
`ifdef MOVE_COUNT_EN
  ,
  output logic [15:0] move_count
`endif
);

  localparam cell_t WIN_CELL = cell_t'(WIN_VALUE);

  state_t      st;
  cell_t       work [16];
  dir_t        dir_q;
  logic [1:0]  idx;
  logic        changed;
  logic [3:0]  ptr;
  logic [3:0]  probes;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        released;
  logic        is_start;
  cell_t [3:0] lin;
  cell_t [3:0] lout;
  logic        line_chg;
  logic        won;
  logic        lost;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign busy     = (st != IDLE);
  assign state    = st;
  assign line_chg = (lout != lin);

  always_comb begin
    for (int j = 0; j < 4; j++)
      lin[j] = work[cell_idx(dir_q, idx, 2'(j))];
  end

  line_merge u_merge (
    .line_in  (lin),
    .line_out (lout)
  );

  always_comb begin
    won  = 1'b0;
    lost = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (work[k] >= WIN_CELL) won = 1'b1;
      if (work[k] == '0) lost = 1'b0;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (work[4*r+c] == work[4*r+c+1]) lost = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (work[4*r+c] == work[4*r+c+4]) lost = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st         <= IDLE;
      for (int k = 0; k < 16; k++) work[k] <= '0;
      dir_q      <= '0;
      idx        <= '0;
      changed    <= 1'b0;
      ptr        <= '0;
      probes     <= '0;
      lfsr       <= LFSR_SEED;
      released   <= 1'b1;
      is_start   <= 1'b0;
      board_out  <= '0;
      board_we   <= 1'b0;
      end_status <= ST_PLAY;
`ifdef MOVE_COUNT_EN
      move_count <= '0;
`endif
    end else begin
      lfsr     <= {lfsr[14:0], lfsr_fb};
      board_we <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            end_status <= ST_PLAY;
            for (int k = 0; k < 16; k++) work[k] <= '0;
            ptr      <= lfsr[3:0];
            probes   <= '0;
            is_start <= 1'b1;
            released <= 1'b0;
            st       <= SPAWN;
          end else if ($onehot(direction) && released &&
                       end_status == ST_PLAY) begin
            dir_q    <= direction;
            released <= 1'b0;
            st       <= LOAD;
          end
        end
        LOAD: begin
          for (int k = 0; k < 16; k++)
            work[k] <= board_in[63-4*k -: 4];
          idx      <= '0;
          changed  <= 1'b0;
          is_start <= 1'b0;
          st       <= MERGE;
        end
        MERGE: begin
          for (int j = 0; j < 4; j++)
            work[cell_idx(dir_q, idx, 2'(j))] <= lout[j];
          changed <= changed | line_chg;
          idx     <= idx + 2'd1;
          if (idx == 2'd3) begin
            ptr    <= lfsr[3:0];
            probes <= '0;
            st     <= (changed | line_chg) ? SPAWN : WAIT_REL;
          end
        end
        SPAWN: begin
          if (work[ptr] == '0) begin
            work[ptr] <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
            st        <= CHECK;
          end else if (probes == 4'd15) begin
            st <= CHECK;
          end else begin
            ptr    <= ptr + 4'd1;
            probes <= probes + 4'd1;
          end
        end
        CHECK: begin
          for (int k = 0; k < 16; k++)
            board_out[63-4*k -: 4] <= work[k];
          board_we   <= 1'b1;
          end_status <= won ? ST_WON : (lost ? ST_LOST : ST_PLAY);
`ifdef MOVE_COUNT_EN
          if (is_start)
            move_count <= '0;
          else if (move_count != 16'hFFFF)
            move_count <= move_count + 16'd1;
`endif
          st <= WRITE;
        end
        WRITE: st <= WAIT_REL;
        WAIT_REL: begin
          if (direction == '0 && !start) begin
            released <= 1'b1;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: moves, no-ops, win/lose, start, reset.
// Board literals are written one hex digit per cell, top-left first.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  direction;
  logic [63:0] board_in;
  logic [63:0] board_out;
  logic        board_we;
  logic        busy;
  logic [1:0]  end_status;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int we;
  int lat;

  always #5 clock = ~clock;

  move_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .direction  (direction),
    .board_in   (board_in),
    .board_out  (board_out),
    .board_we   (board_we),
    .busy       (busy),
    .end_status (end_status),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nz_count(input logic [63:0] b,
                                  input logic [15:0] mask);
    int n = 0;
    for (int k = 0; k < 16; k++)
      if (mask[k] && b[63-4*k -: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic int nz_sum(input logic [63:0] b,
                                input logic [15:0] mask);
    int s = 0;
    for (int k = 0; k < 16; k++)
      if (mask[k]) s += int'(b[63-4*k -: 4]);
    return s;
  endfunction

  // Drive a request, drop it after 'hold' edges, count board_we pulses.
  task automatic run(input logic [3:0] d, input logic s, input int hold,
                     output int n_we, output int first);
    direction = d;
    start     = s;
    n_we      = 0;
    first     = -1;
    for (int c = 1; c <= hold + 40; c++) begin
      @(posedge clock); #1;
      if (c == hold) begin
        direction = 4'd0;
        start     = 1'b0;
      end
      if (board_we) begin
        n_we++;
        if (first < 0) first = c - 1;
      end
    end
  endtask

  task automatic chk_spawn(input string tag, input logic [15:0] mask);
    int v;
    chk({tag, "_spawn_cnt"}, nz_count(board_out, mask), 1);
    v = nz_sum(board_out, mask);
    chk({tag, "_spawn_val"}, (v == 1) || (v == 2), 1);
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    direction = 4'd0;
    board_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_board_out", board_out, 0);
    chk("rst_board_we", board_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_end_status", end_status, 0);
    chk("rst_state", state, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    board_in = 64'h1120_0000_0000_0000;
    run(4'b0010, 1'b0, 1, we, lat);
    chk("left_we_cnt", we, 1);
    chk("left_latency", (lat >= 7) && (lat <= 22), 1);
    chk("left_row0", board_out[63:56], 8'h22);
    chk_spawn("left", 16'hFFFC);
    chk("left_idle", busy, 0);

    board_in = 64'h3200_0000_0000_0000;
    run(4'b0010, 1'b0, 1, we, lat);
    chk("noop_we_cnt", we, 0);
    chk("noop_busy", busy, 0);
    chk("noop_state", state, 0);

    board_in = 64'h2222_0000_0000_0000;
    run(4'b0010, 1'b0, 1, we, lat);
    chk("quad_we_cnt", we, 1);
    chk("quad_row0", board_out[63:56], 8'h33);
    chk_spawn("quad", 16'hFFFC);

    board_in = 64'h1120_0000_0000_0000;
    run(4'b0010, 1'b0, 1000, we, lat);
    chk("hold_we_cnt", we, 1);
    chk("hold_busy", busy, 0);

    run(4'b0011, 1'b0, 1, we, lat);
    chk("multi_we_cnt", we, 0);
    chk("multi_state", state, 0);

    board_in  = 64'h1120_0000_0000_0000;
    direction = 4'b0010;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_state_merge", state, 2);
    resetn = 1'b0;
    #1;
    chk("mid_rst_board_out", board_out, 0);
    chk("mid_rst_we", board_we, 0);
    chk("mid_rst_state", state, 0);
    direction = 4'd0;
    @(posedge clock); #1;
    resetn = 1'b1;
    run(4'b0000, 1'b0, 1, we, lat);
    chk("mid_rst_no_we", we, 0);

    board_in = 64'hAA00_0000_0000_0000;
    run(4'b0001, 1'b0, 1, we, lat);
    chk("win_we_cnt", we, 1);
    chk("win_cell3", board_out[51:48], 4'hB);
    chk("win_status", end_status, 2'b01);
    chk_spawn("win", 16'hFFF7);

    board_in = board_out;
    run(4'b0010, 1'b0, 1, we, lat);
    chk("won_locked_we", we, 0);
    chk("won_locked_status", end_status, 2'b01);

    run(4'b0000, 1'b1, 1, we, lat);
    chk("start_we_cnt", we, 1);
    chk("start_one_tile", nz_count(board_out, 16'hFFFF), 1);
    chk_spawn("start", 16'hFFFF);
    chk("start_status", end_status, 2'b00);

    board_in = 64'h3405_1216_2121_1212;
    run(4'b0010, 1'b0, 1, we, lat);
    chk("lose_we_cnt", we, 1);
    chk("lose_board", board_out & ~64'h000F_0000_0000_0000,
        64'h3450_1216_2121_1212);
    chk_spawn("lose", 16'h0008);
    chk("lose_status", end_status, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
